// File: rtl/decode_queue.sv
// decode_queue: instruction-decode stage with a DEPTH-entry queue between fetch
// and register read. Accepted {Ins, PC} pairs are buffered in a circular queue.
// The head entry is split combinationally into MIPS R/I/J fields, the extended
// immediate, the branch target and the jump target.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   Flush               clears the queue on the next edge (taken branch/jump)
//   InValid/InReady     producer handshake for Ins and PC
//   Ins, PC             instruction word and its address
//   OutValid/OutReady   consumer handshake for the head entry
//   Opcode..Address     raw instruction fields of the head entry
//   ExtImm              zero-, sign- or lui-extended immediate
//   BranchTarget        PC+4 + (sext(imm) << 2), modulo 2^ADDR_WIDTH
//   JumpTarget          {(PC+4)[ADDR_WIDTH-1:28], Address, 2'b00}
//   OutPC               PC of the head entry
//   Count               queue occupancy
module decode_queue #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         Flush,
   input  logic                         InValid,
   output logic                         InReady,
   input  logic [31:0]                  Ins,
   input  logic [ADDR_WIDTH-1:0]        PC,
   output logic                         OutValid,
   input  logic                         OutReady,
   output logic [5:0]                   Opcode,
   output logic [5:0]                   Funct,
   output logic [4:0]                   Shamt,
   output logic [4:0]                   rs,
   output logic [4:0]                   rt,
   output logic [4:0]                   rd,
   output logic [15:0]                  Immediate,
   output logic [25:0]                  Address,
   output logic [31:0]                  ExtImm,
   output logic [ADDR_WIDTH-1:0]        BranchTarget,
   output logic [ADDR_WIDTH-1:0]        JumpTarget,
   output logic [ADDR_WIDTH-1:0]        OutPC,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]           ins_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count_q;

   logic enq;
   logic deq;

   // Handshake status depends only on registered occupancy.
   assign InReady  = (count_q < CNT_W'(DEPTH));
   assign OutValid = (count_q != '0);
   assign Count    = count_q;
   assign enq      = InValid && InReady;
   assign deq      = OutValid && OutReady;

   // Queue storage, pointers and occupancy; reset and flush override traffic.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ins_mem[PTR_W'(i)] <= '0;
            pc_mem[PTR_W'(i)]  <= '0;
         end
      end else if (Flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            ins_mem[wr_ptr] <= Ins;
            pc_mem[wr_ptr]  <= PC;
            wr_ptr          <= PTR_W'(wr_ptr + PTR_W'(1));
         end
         if (deq) begin
            rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
         end
         if (enq && !deq) begin
            count_q <= CNT_W'(count_q + CNT_W'(1));
         end else if (!enq && deq) begin
            count_q <= CNT_W'(count_q - CNT_W'(1));
         end
      end
   end

   logic [31:0]           head_ins;
   logic [ADDR_WIDTH-1:0] head_pc;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic [ADDR_WIDTH-1:0] branch_off;

   // Head entry, zeroed when the queue is empty so every field reads 0.
   always_comb begin
      head_ins = '0;
      head_pc  = '0;
      if (OutValid) begin
         head_ins = ins_mem[rd_ptr];
         head_pc  = pc_mem[rd_ptr];
      end
   end

   assign Opcode    = head_ins[31:26];
   assign rs        = head_ins[25:21];
   assign rt        = head_ins[20:16];
   assign rd        = head_ins[15:11];
   assign Shamt     = head_ins[10:6];
   assign Funct     = head_ins[5:0];
   assign Immediate = head_ins[15:0];
   assign Address   = head_ins[25:0];
   assign OutPC     = head_pc;

   // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
   always_comb begin
      ExtImm = {{16{head_ins[15]}}, head_ins[15:0]};
      case (head_ins[31:26])
         6'h0C, 6'h0D, 6'h0E: ExtImm = {16'h0000, head_ins[15:0]};
         6'h0F:               ExtImm = {head_ins[15:0], 16'h0000};
         default:             ;
      endcase
   end

   // Targets wrap modulo 2^ADDR_WIDTH; the jump mask keeps only PC+4 bits above 27,
   // which is an empty slice when ADDR_WIDTH is 28.
   assign pc_plus4     = ADDR_WIDTH'(head_pc + ADDR_WIDTH'(4));
   assign branch_off   = ADDR_WIDTH'({{14{head_ins[15]}}, head_ins[15:0], 2'b00});
   assign BranchTarget = OutValid ? ADDR_WIDTH'(pc_plus4 + branch_off) : '0;
   assign JumpTarget   = OutValid ? ((pc_plus4 & ~ADDR_WIDTH'(28'hFFF_FFFF)) |
                                     ADDR_WIDTH'({head_ins[25:0], 2'b00}))
                                  : '0;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-of-entries model tracks what the DUT must hold,
// a negedge process compares every output against it, and directed steps pin
// a set of hand-computed values before a long randomized run.
module tb_decode_queue;

   localparam int AW    = 32;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_i;
   logic          flush_i;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   ins_i;
   logic [AW-1:0] pc_i;
   logic          out_valid;
   logic          out_ready;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [4:0]    shamt;
   logic [4:0]    rs_o;
   logic [4:0]    rt_o;
   logic [4:0]    rd_o;
   logic [15:0]   immediate;
   logic [25:0]   address;
   logic [31:0]   ext_imm;
   logic [AW-1:0] branch_target;
   logic [AW-1:0] jump_target;
   logic [AW-1:0] out_pc;
   logic [CW-1:0] count;

   decode_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST(rst_i), .Flush(flush_i),
      .InValid(in_valid), .InReady(in_ready), .Ins(ins_i), .PC(pc_i),
      .OutValid(out_valid), .OutReady(out_ready),
      .Opcode(opcode), .Funct(funct), .Shamt(shamt),
      .rs(rs_o), .rt(rt_o), .rd(rd_o),
      .Immediate(immediate), .Address(address), .ExtImm(ext_imm),
      .BranchTarget(branch_target), .JumpTarget(jump_target),
      .OutPC(out_pc), .Count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit started = 1'b0;

   // Model: entries {ins, pc} in arrival order, head at index 0.
   logic [63:0] model_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all outputs against the model's head entry.
   always @(negedge clk) begin : compare
      logic [31:0] m_ins;
      logic [31:0] m_pc;
      logic [31:0] m_p4;
      logic [31:0] e_ext;
      logic [31:0] e_br;
      logic [31:0] e_j;
      logic [15:0] m_imm;
      bit          m_valid;
      if (started) begin
         m_valid = (model_q.size() != 0);
         m_ins   = '0;
         m_pc    = '0;
         if (m_valid) {m_ins, m_pc} = model_q[0];
         m_imm = m_ins[15:0];
         m_p4  = m_pc + 32'd4;
         if (m_ins[31:26] == 6'h0C || m_ins[31:26] == 6'h0D || m_ins[31:26] == 6'h0E)
            e_ext = {16'h0000, m_imm};
         else if (m_ins[31:26] == 6'h0F)
            e_ext = {m_imm, 16'h0000};
         else
            e_ext = 32'(int'($signed(m_imm)));
         e_br = m_p4 + 32'(int'($signed(m_imm)) * 4);
         e_j  = {m_p4[31:28], m_ins[25:0], 2'b00};
         if (!m_valid) begin
            e_ext = '0;
            e_br  = '0;
            e_j   = '0;
         end
         chk("InReady",      64'(in_ready),      64'(model_q.size() < DEPTH));
         chk("OutValid",     64'(out_valid),     64'(m_valid));
         chk("Count",        64'(count),         64'(model_q.size()));
         chk("Opcode",       64'(opcode),        64'(m_ins[31:26]));
         chk("rs",           64'(rs_o),          64'(m_ins[25:21]));
         chk("rt",           64'(rt_o),          64'(m_ins[20:16]));
         chk("rd",           64'(rd_o),          64'(m_ins[15:11]));
         chk("Shamt",        64'(shamt),         64'(m_ins[10:6]));
         chk("Funct",        64'(funct),         64'(m_ins[5:0]));
         chk("Immediate",    64'(immediate),     64'(m_imm));
         chk("Address",      64'(address),       64'(m_ins[25:0]));
         chk("ExtImm",       64'(ext_imm),       64'(e_ext));
         chk("BranchTarget", 64'(branch_target), 64'(e_br));
         chk("JumpTarget",   64'(jump_target),   64'(e_j));
         chk("OutPC",        64'(out_pc),        64'(m_pc));
      end
   end

   // One clock of stimulus; the model applies the same rules at the edge.
   task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit rs);
      bit e;
      bit d;
      in_valid  = v;
      ins_i     = ins;
      pc_i      = pc;
      out_ready = ordy;
      flush_i   = fl;
      rst_i     = rs;
      @(posedge clk);
      if (rs || fl) begin
         model_q.delete();
      end else begin
         e = v && (model_q.size() < DEPTH);
         d = (model_q.size() != 0) && ordy;
         if (d) void'(model_q.pop_front());
         if (e) model_q.push_back({ins, pc});
      end
      #1;
   endtask

   initial begin
      logic [31:0] r_ins;
      logic [5:0]  r_op;
      bit          r_ordy;
      in_valid = 1'b0; ins_i = '0; pc_i = '0; out_ready = 1'b0;
      flush_i = 1'b0; rst_i = 1'b1;

      // Reset state
      cyc(0, 0, 0, 0, 0, 1);
      started = 1'b1;
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst_InReady", 64'(in_ready), 64'd1);
      chk("rst_OutValid", 64'(out_valid), 64'd0);
      chk("rst_Count", 64'(count), 64'd0);
      chk("rst_BranchTarget", 64'(branch_target), 64'd0);
      chk("rst_JumpTarget", 64'(jump_target), 64'd0);

      // R-type decode
      cyc(1, 32'h012A4020, 32'h00400000, 0, 0, 0);
      chk("r_OutValid", 64'(out_valid), 64'd1);
      chk("r_rs", 64'(rs_o), 64'd9);
      chk("r_rt", 64'(rt_o), 64'd10);
      chk("r_rd", 64'(rd_o), 64'd8);
      chk("r_Funct", 64'(funct), 64'h20);
      chk("r_OutPC", 64'(out_pc), 64'h00400000);
      cyc(0, 0, 0, 1, 0, 0);
      chk("r_drain_Count", 64'(count), 64'd0);

      // Immediate extension, back-to-back
      cyc(1, 32'h2128FFFF, 32'h00400000, 1, 0, 0);
      chk("ext_addi", 64'(ext_imm), 64'hFFFFFFFF);
      cyc(1, 32'h3528FFFF, 32'h00400004, 1, 0, 0);
      chk("ext_ori", 64'(ext_imm), 64'h0000FFFF);
      cyc(1, 32'h3C081234, 32'h00400008, 1, 0, 0);
      chk("ext_lui", 64'(ext_imm), 64'h12340000);
      chk("ext_Count", 64'(count), 64'd1);
      cyc(0, 0, 0, 1, 0, 0);

      // Branch and jump targets
      cyc(1, 32'h1000FFFF, 32'h00400000, 0, 0, 0);
      chk("beq_target", 64'(branch_target), 64'h00400000);
      cyc(1, 32'h08100000, 32'h00400000, 1, 0, 0);
      chk("j_target", 64'(jump_target), 64'h00400000);
      cyc(1, 32'h1000FFFF, 32'hFFFFFFFC, 1, 0, 0);
      chk("beq_wrap", 64'(branch_target), 64'hFFFFFFFC);
      chk("j_wrap", 64'(jump_target), 64'h0003FFFC);
      cyc(0, 0, 0, 1, 0, 0);

      // Backpressure: third offer refused, then drain in order
      cyc(1, 32'h00000001, 32'h00000100, 0, 0, 0);
      cyc(1, 32'h00000002, 32'h00000104, 0, 0, 0);
      chk("bp_Count_full", 64'(count), 64'd2);
      chk("bp_InReady_full", 64'(in_ready), 64'd0);
      cyc(1, 32'h00000003, 32'h00000108, 0, 0, 0);
      chk("bp_Count_held", 64'(count), 64'd2);
      chk("bp_head_held", 64'(out_pc), 64'h00000100);
      cyc(1, 32'h00000003, 32'h00000108, 1, 0, 0);
      chk("bp_full_deq_Count", 64'(count), 64'd1);
      chk("bp_head_2", 64'(out_pc), 64'h00000104);
      cyc(1, 32'h00000003, 32'h00000108, 1, 0, 0);
      chk("bp_simul_Count", 64'(count), 64'd1);
      chk("bp_head_3", 64'(out_pc), 64'h00000108);
      cyc(0, 0, 0, 1, 0, 0);
      chk("bp_empty", 64'(count), 64'd0);

      // Flush with an offered instruction in the same cycle
      cyc(1, 32'h00000011, 32'h00000200, 0, 0, 0);
      cyc(1, 32'h00000012, 32'h00000204, 0, 0, 0);
      cyc(1, 32'h00000013, 32'h00000208, 0, 1, 0);
      chk("fl_Count", 64'(count), 64'd0);
      chk("fl_OutValid", 64'(out_valid), 64'd0);
      chk("fl_InReady", 64'(in_ready), 64'd1);
      cyc(1, 32'h00000014, 32'h0000020C, 0, 0, 0);
      chk("fl_after_Count", 64'(count), 64'd1);
      chk("fl_after_head", 64'(out_pc), 64'h0000020C);

      // Reset mid-stream
      cyc(1, 32'h2128FFFF, 32'h00000210, 0, 0, 0);
      cyc(1, 32'h3C081234, 32'h00000214, 1, 0, 1);
      chk("mr_Count", 64'(count), 64'd0);
      chk("mr_OutValid", 64'(out_valid), 64'd0);
      chk("mr_OutPC", 64'(out_pc), 64'd0);
      chk("mr_ExtImm", 64'(ext_imm), 64'd0);
      chk("mr_BranchTarget", 64'(branch_target), 64'd0);

      // Randomized traffic with phases of heavy backpressure
      for (int n = 0; n < 3000; n++) begin
         r_ins = $urandom;
         case ($urandom_range(0, 7))
            0: r_op = 6'h0C;
            1: r_op = 6'h0D;
            2: r_op = 6'h0E;
            3: r_op = 6'h0F;
            4: r_op = 6'h04;
            default: r_op = 6'($urandom_range(0, 63));
         endcase
         r_ins[31:26] = r_op;
         if (n >= 1000 && n < 1600) r_ordy = ($urandom_range(0, 3) == 0);
         else                       r_ordy = ($urandom_range(0, 3) != 0);
         cyc($urandom_range(0, 3) != 0, r_ins, $urandom, r_ordy,
             $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
      end
      cyc(0, 0, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised instruction-decode stage with a DEPTH-entry queue and valid/ready handshakes on both sides, placed between instruction fetch and register read. It splits each accepted 32-bit MIPS instruction into its R/I/J fields and additionally produces the extended immediate, branch target and jump target. Fetch can run ahead of a stalled back end by up to DEPTH instructions, and a flush discards everything queued.

## Interface
- ADDR_WIDTH, 32, width of PC and computed targets; legal range 28..32
- DEPTH, 2, queue entries; power of two, ≥2
- CLK  in  1  sole clock, rising edge
- RST  in  1  reset, synchronous, active-high
- Flush  in  1  synchronous queue clear (taken branch/jump)
- InValid  in  1  Ins/PC valid this cycle
- InReady  out  1  queue can accept
- Ins  in  32  instruction word
- PC  in  ADDR_WIDTH  address of Ins
- OutValid  out  1  head entry valid
- OutReady  in  1  consumer accepts head
- Opcode  out  6  Ins[31:26] of head
- Funct  out  6  Ins[5:0]
- Shamt  out  5  Ins[10:6]
- rs  out  5  Ins[25:21]
- rt  out  5  Ins[20:16]
- rd  out  5  Ins[15:11]
- Immediate  out  16  Ins[15:0]
- Address  out  26  Ins[25:0]
- ExtImm  out  32  extended immediate
- BranchTarget  out  ADDR_WIDTH  PC+4+(sext(Immediate)<<2)
- JumpTarget  out  ADDR_WIDTH  {(PC+4)[ADDR_WIDTH-1:28], Address, 2'b00}
- OutPC  out  ADDR_WIDTH  PC of head
- Count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage: circular buffer of DEPTH entries {Ins, PC}, write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
- Enqueue: InValid && InReady. InReady = (Count < DEPTH); it depends only on registered state, never combinationally on OutReady.
- Dequeue: OutValid && OutReady. OutValid = (Count != 0).
- Simultaneous enqueue and dequeue: Count is unchanged and both pointers advance. When full, InReady=0 and no enqueue occurs, even if a dequeue happens in the same cycle.
- Flush: pointers and Count are cleared next edge. Any enqueue or dequeue in that cycle is discarded; Flush has priority over both.
- RST: same effect as Flush, and also clears all storage entries to 0.
- Field outputs are decoded combinationally from the head entry. When OutValid=0, every field/target output and OutPC is forced to 0.
- ExtImm rules:
  - Opcode 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend.
  - Opcode 0x0F (lui): {Immediate, 16'h0000}.
  - All other opcodes: sign-extend.
- Arithmetic: PC+4 and BranchTarget are computed modulo 2^ADDR_WIDTH, with wrap and no error flag. When ADDR_WIDTH=28, the upper PC slice of JumpTarget is empty and JumpTarget = {Address, 2'b00}.
- The decoder does not judge instruction legality; unknown opcodes pass through with sign-extended ExtImm.

## Timing
- Reset values: InReady=1, OutValid=0, Count=0, all field/target outputs 0.
- Latency: an instruction accepted at edge N is visible with OutValid=1 in the cycle after edge N; there is no combinational path from Ins to the outputs.
- Throughput: 1 instruction/cycle sustained when OutReady=1.
- Head outputs are stable while OutValid=1 && OutReady=0.
- Flush asserted in cycle N: OutValid=0 and InReady=1 after edge N; the first post-flush instruction may be accepted in cycle N+1.
- RST mid-stream: same cycle behaviour as Flush.

## Test plan
- R-type: Ins=0x012A4020 at PC=0x00400000 -> next cycle OutValid=1, Opcode=0, rs=9, rt=10, rd=8, Shamt=0, Funct=0x20, OutPC=0x00400000.
- Extension: Ins 0x2128FFFF, 0x3528FFFF, 0x3C081234 enqueued back-to-back with OutReady=1 -> ExtImm = 0xFFFFFFFF, then 0x0000FFFF, then 0x12340000 on consecutive cycles.
- Targets:
  - beq 0x1000FFFF at PC=0x00400000 -> BranchTarget=0x00400000.
  - j 0x08100000 at PC=0x00400000 -> JumpTarget=0x00400000.
  - PC=0xFFFFFFFC -> BranchTarget wraps to 0xFFFFFFFC for imm=0xFFFF.
- Backpressure (DEPTH=2): OutReady=0 while 3 instructions are offered -> InReady drops after 2 accepts, Count=2, the 3rd is held by the producer. Then raise OutReady -> all 3 drain in order, with no loss or duplication.
- Simultaneous enqueue and dequeue at Count=1 -> Count stays 1 and order is preserved. At Count=DEPTH with OutReady=1 -> dequeue only, Count=DEPTH-1.
- Flush/reset: Flush with Count=2 and InValid=1 in the same cycle -> next cycle Count=0, OutValid=0, and the offered instruction is dropped. RST mid-stream gives the same result with all outputs 0.
